sequence_verifier: RTL and testbench
====================================

SEQUENCE_VERIFIER -- requirements
Module: sequence_verifier

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, cycles a pass/fail result is held before the end code.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse, begin a new game at level 1.
REQ-005 time_up  input  1  level-sensitive, game timer expired.
REQ-006 digit_valid  input  1  one-cycle pulse, debounced player entry.
REQ-007 digit_in  input  4  entered digit, sampled when digit_valid=1.
REQ-008 s_results  output  2  00 in progress/idle, 01 game success, 10 game fail, 11 sequence end.
REQ-009 level  output  2  current level 1..3; 0 when idle.
REQ-010 digit_idx  output  3  index of next expected digit in current level.

Function
REQ-011 States SHALL be IDLE, ENTRY, SUCCESS_HOLD, FAIL_HOLD and END.
REQ-012 IDLE: start=1 -> ENTRY, level=1, digit_idx=0; all other inputs ignored.
REQ-013 Level sequence lengths SHALL be 4, 6 and 8 digits for levels 1, 2 and 3; target digits come from a fixed lookup indexed by (level, digit_idx).
REQ-014 ENTRY, digit_valid=1, digit_in equals the target: digit_idx increments; on the last digit of levels 1-2, level increments and digit_idx clears to 0; on the last digit of level 3 -> SUCCESS_HOLD.
REQ-015 ENTRY, digit_valid=1, digit_in differs from the target (including any value >9) -> FAIL_HOLD.
REQ-016 ENTRY, time_up=1 -> FAIL_HOLD regardless of digit_valid; time_up SHALL take priority over a same-cycle digit.
REQ-017 Outputs SHALL be registered; s_results reflects a sampled digit exactly one cycle after the digit_valid cycle.
REQ-018 SUCCESS_HOLD SHALL drive s_results=01 and FAIL_HOLD SHALL drive 10, each for exactly HOLD_CYCLES cycles, then -> END.
REQ-019 END SHALL drive s_results=11 for exactly one cycle, then -> IDLE with s_results=00, level=0, digit_idx=0.
REQ-020 In ENTRY, s_results SHALL remain 00, including across level advances.
REQ-021 start, digit_valid and time_up SHALL be ignored in SUCCESS_HOLD, FAIL_HOLD and END; start in ENTRY SHALL be ignored.
REQ-022 level and digit_idx SHALL hold their final values during SUCCESS_HOLD and FAIL_HOLD.
REQ-023 The hold counter SHALL be sized as ceil(log2(HOLD_CYCLES+1)) bits, load on entry to a hold state, and never wrap.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE, s_results=00, level=0, digit_idx=0 and hold counter 0, from any state including mid-hold.
REQ-025 The first edge after rst returns high SHALL evaluate IDLE rules; a start asserted in that cycle is accepted.

Structure
REQ-026 A shared package SHALL hold the state encoding, result codes (RES_BUSY=00, RES_PASS=01, RES_FAIL=10, RES_END=11) and the per-level lengths.
REQ-027 The target lookup SHALL be a combinational sub-module sequence_rom (inputs level, digit_idx; output 4-bit digit); all other logic stays in sequence_verifier.

Verification
REQ-028 Reset then start, enter all 18 correct digits -> s_results 00 throughout, level 1->2->3, then 01 for HOLD_CYCLES, 11 for 1 cycle, 00 with level=0.
REQ-029 Start, 2 correct digits, then a wrong digit -> s_results=10 on the next cycle, level=1, digit_idx=2, then 11 after HOLD_CYCLES.
REQ-030 In level 2, time_up and a correct digit_valid in the same cycle -> FAIL_HOLD (10); digit_idx does not advance.
REQ-031 Entering digit_in=4'hF at any index -> treated as a mismatch, s_results=10.
REQ-032 rst=0 mid SUCCESS_HOLD -> next cycle s_results=00, level=0; a subsequent start restarts at level 1.
REQ-033 digit_valid and start pulses during FAIL_HOLD and END -> no change to level, digit_idx or hold duration.

Source files
------------

// File: rtl/sequence_verifier_pkg.sv
// Shared types and constants for the sequence verifier game.
// Holds state encoding, result codes and per-level sequence lengths.
package sequence_verifier_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_SUCC_HOLD = 3'd2,
    S_FAIL_HOLD = 3'd3,
    S_END       = 3'd4
  } sv_state_e;

  localparam logic [1:0] RES_BUSY = 2'b00;
  localparam logic [1:0] RES_PASS = 2'b01;
  localparam logic [1:0] RES_FAIL = 2'b10;
  localparam logic [1:0] RES_END  = 2'b11;

  localparam int LEN_L1 = 4;
  localparam int LEN_L2 = 6;
  localparam int LEN_L3 = 8;

  // Index of the final digit of a level; level 0 never reaches ENTRY.
  function automatic logic [2:0] last_idx(input logic [1:0] lvl);
    case (lvl)
      2'd1:    last_idx = 3'(LEN_L1 - 1);
      2'd2:    last_idx = 3'(LEN_L2 - 1);
      default: last_idx = 3'(LEN_L3 - 1);
    endcase
  endfunction

endpackage

// File: rtl/sequence_verifier_rom.sv
// Combinational target-digit lookup indexed by (level, digit_idx).
// Unused slots return 0; they are unreachable from ENTRY.
module sequence_rom
  import sequence_verifier_pkg::*;
(
  input  logic [1:0] level,
  input  logic [2:0] digit_idx,
  output logic [3:0] digit
);

  always_comb begin
    digit = 4'd0;
    case ({level, digit_idx})
      {2'd1, 3'd0}: digit = 4'd3;
      {2'd1, 3'd1}: digit = 4'd1;
      {2'd1, 3'd2}: digit = 4'd4;
      {2'd1, 3'd3}: digit = 4'd1;
      {2'd2, 3'd0}: digit = 4'd5;
      {2'd2, 3'd1}: digit = 4'd9;
      {2'd2, 3'd2}: digit = 4'd2;
      {2'd2, 3'd3}: digit = 4'd6;
      {2'd2, 3'd4}: digit = 4'd5;
      {2'd2, 3'd5}: digit = 4'd3;
      {2'd3, 3'd0}: digit = 4'd5;
      {2'd3, 3'd1}: digit = 4'd8;
      {2'd3, 3'd2}: digit = 4'd9;
      {2'd3, 3'd3}: digit = 4'd7;
      {2'd3, 3'd4}: digit = 4'd9;
      {2'd3, 3'd5}: digit = 4'd3;
      {2'd3, 3'd6}: digit = 4'd2;
      {2'd3, 3'd7}: digit = 4'd3;
      default:      digit = 4'd0;
    endcase
  end

endmodule

// File: rtl/sequence_verifier.sv
// Three-level digit-entry game: checks entered digits against a fixed
// sequence, then holds a pass/fail code for HOLD_CYCLES before an end code.
module sequence_verifier
  import sequence_verifier_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       time_up,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  output logic [1:0] s_results,
  output logic [1:0] level,
  output logic [2:0] digit_idx
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  sv_state_e         state_q, state_d;
  logic [1:0]        res_q, res_d;
  logic [1:0]        lvl_q, lvl_d;
  logic [2:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        target;

  sequence_rom u_rom (
    .level     (lvl_q),
    .digit_idx (idx_q),
    .digit     (target)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= RES_BUSY;
      lvl_q   <= 2'd0;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        res_d = RES_BUSY;
        lvl_d = 2'd0;
        idx_d = 3'd0;
        cnt_d = '0;
        if (start) begin
          state_d = S_ENTRY;
          lvl_d   = 2'd1;
        end
      end
      S_ENTRY: begin
        // time_up wins over a same-cycle digit; level/idx freeze on failure.
        if (time_up || (digit_valid && digit_in != target)) begin
          state_d = S_FAIL_HOLD;
          res_d   = RES_FAIL;
          cnt_d   = HOLD_W'(HOLD_CYCLES);
        end else if (digit_valid) begin
          if (idx_q == last_idx(lvl_q)) begin
            if (lvl_q == 2'd3) begin
              state_d = S_SUCC_HOLD;
              res_d   = RES_PASS;
              cnt_d   = HOLD_W'(HOLD_CYCLES);
            end else begin
              lvl_d = lvl_q + 2'd1;
              idx_d = 3'd0;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_SUCC_HOLD, S_FAIL_HOLD: begin
        if (cnt_q <= HOLD_W'(1)) begin
          state_d = S_END;
          res_d   = RES_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      S_END: begin
        state_d = S_IDLE;
        res_d   = RES_BUSY;
        lvl_d   = 2'd0;
        idx_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        res_d   = RES_BUSY;
        lvl_d   = 2'd0;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  assign s_results = res_q;
  assign level     = lvl_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_sequence_verifier.sv
// Directed bench for sequence_verifier: a vector table for the fail path
// plus hand-written sequences for success, time_up, bad digit and reset.
module tb_sequence_verifier;

  localparam int HOLD = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       time_up = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [1:0] s_results;
  logic [1:0] level;
  logic [2:0] digit_idx;

  int nchk = 0;
  int nerr = 0;

  sequence_verifier #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .time_up     (time_up),
    .digit_valid (digit_valid),
    .digit_in    (digit_in),
    .s_results   (s_results),
    .level       (level),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       tu;
    logic       dv;
    logic [3:0] d;
    logic [1:0] e_res;
    logic [1:0] e_lvl;
    logic [2:0] e_idx;
  } vec_t;

  vec_t       tbl [13];
  logic [3:0] dig [18];

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] r,
                           input logic [1:0] l, input logic [2:0] i);
    check({name, ".res"}, int'(s_results), int'(r));
    check({name, ".lvl"}, int'(level), int'(l));
    check({name, ".idx"}, int'(digit_idx), int'(i));
  endtask

  // Apply current inputs across one rising edge, then clear the pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    digit_valid = 1'b0;
    time_up = 1'b0;
    digit_in = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic enter(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_in = d;
    tick();
  endtask

  // Start a game and enter all 18 correct digits, checking each step.
  task automatic run_success();
    int base, len, pos;
    logic [1:0] el;
    logic [2:0] ei;
    start = 1'b1;
    tick();
    check_all("succ.start", 2'b00, 2'd1, 3'd0);
    for (int k = 0; k < 18; k++) begin
      enter(dig[k]);
      base = (k < 4) ? 0 : (k < 10) ? 4 : 10;
      len  = (k < 4) ? 4 : (k < 10) ? 6 : 8;
      el   = (k < 4) ? 2'd1 : (k < 10) ? 2'd2 : 2'd3;
      pos  = k - base + 1;
      if (k == 17) begin
        check("succ.pass.res", int'(s_results), 1);
        check("succ.pass.lvl", int'(level), 3);
      end else begin
        if (pos == len) begin
          el = el + 2'd1;
          ei = 3'd0;
        end else begin
          ei = 3'(pos);
        end
        check_all($sformatf("succ.d%0d", k), 2'b00, el, ei);
      end
    end
  endtask

  initial begin
    dig = '{4'd3, 4'd1, 4'd4, 4'd1,
            4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3,
            4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3, 4'd2, 4'd3};

    // rst_n st tu dv d  res  lvl idx : wrong digit at index 2, then hold/end
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'd0, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'd1, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 2'b00, 2'd1, 3'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 2'b00, 2'd1, 3'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 2'b10, 2'd1, 3'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 2'b10, 2'd1, 3'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 2'b10, 2'd1, 3'd2};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b10, 2'd1, 3'd2};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 2'b10, 2'd1, 3'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 2'b11, 2'd1, 3'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 2'b00, 2'd0, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'd0, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 2'b00, 2'd0, 3'd0};

    #2;
    for (int v = 0; v < 13; v++) begin
      rst = tbl[v].rst_n;
      start = tbl[v].st;
      time_up = tbl[v].tu;
      digit_valid = tbl[v].dv;
      digit_in = tbl[v].d;
      tick();
      check_all($sformatf("vec%0d", v), tbl[v].e_res, tbl[v].e_lvl, tbl[v].e_idx);
    end

    // Full success run through all three levels, hold, end, idle.
    do_reset();
    run_success();
    for (int h = 1; h < HOLD; h++) begin
      start = 1'b1;
      digit_valid = 1'b1;
      digit_in = 4'd3;
      tick();
      check($sformatf("succ.hold%0d.res", h), int'(s_results), 1);
      check($sformatf("succ.hold%0d.lvl", h), int'(level), 3);
    end
    tick();
    check("succ.end.res", int'(s_results), 3);
    tick();
    check_all("succ.idle", 2'b00, 2'd0, 3'd0);

    // Level 2: time_up with a correct digit in the same cycle.
    start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) enter(dig[k]);
    check_all("tu.pre", 2'b00, 2'd2, 3'd2);
    time_up = 1'b1;
    digit_valid = 1'b1;
    digit_in = 4'd2;
    tick();
    check_all("tu.fail", 2'b10, 2'd2, 3'd2);

    // Out-of-range digit counts as a mismatch.
    do_reset();
    check_all("bad.rst", 2'b00, 2'd0, 3'd0);
    start = 1'b1;
    tick();
    enter(4'hF);
    check_all("bad.fail", 2'b10, 2'd1, 3'd0);

    // Reset during success hold, start accepted on the first edge after.
    do_reset();
    run_success();
    tick();
    check("rsthold.pre", int'(s_results), 1);
    rst = 1'b0;
    tick();
    check_all("rsthold.rst", 2'b00, 2'd0, 3'd0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check_all("rsthold.start", 2'b00, 2'd1, 3'd0);
    enter(4'd3);
    check_all("rsthold.d0", 2'b00, 2'd1, 3'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
